// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU and a single
// result slot tagged with its owner. One-cycle latency from accept to
// response. Optional feature macro: ALU_ARB_RR_EN selects round-robin
// arbitration; without it port 0 has fixed priority with a starvation
// limit (STARVE_LIMIT consecutive port-0 grants while port 1 waits).
module alu_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_alufn,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_alufn,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_s,
  output logic        rsp0_z,
  output logic        rsp0_v,
  output logic        rsp0_n,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_s,
  output logic        rsp1_z,
  output logic        rsp1_v,
  output logic        rsp1_n
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL0 = 2'd1;
  localparam logic [1:0] FULL1 = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_s;
  logic        r_z;
  logic        r_v;
  logic        r_n;

  logic        w_free;
  logic        w_pick1;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_acc0;
  logic        w_acc1;

  logic [5:0]  w_fn;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_bx;
  logic [31:0] w_add;
  logic [31:0] w_diff;
  logic [31:0] w_bool;
  logic        w_add_v;
  logic        w_sub_z;
  logic        w_sub_v;
  logic        w_sub_n;
  logic        w_lt;
  logic        w_lsb;
  logic [31:0] w_alu_s;
  logic        w_alu_z;
  logic        w_alu_v;
  logic        w_alu_n;

  // ---------------------------------------------------------------------
  // Arbitration: w_pick1 says who wins when both ports are valid.
  // ---------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
  // 1 means port 1 was granted most recently; reset value favours port 0.
  logic r_last;

  assign w_pick1 = ~r_last;

  // Remember the most recently accepted port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_acc0) begin
      r_last <= 1'b0;
    end else if (w_acc1) begin
      r_last <= 1'b1;
    end
  end
`else
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve;

  assign w_pick1 = (r_starve == LIM);

  // Count port-0 wins while port 1 is waiting; any port-1 accept clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_acc1) begin
      r_starve <= '0;
    end else if (w_acc0 && req1_valid && (r_starve != LIM)) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`endif

  assign w_grant1 = req1_valid & (~req0_valid | w_pick1);
  assign w_grant0 = req0_valid & ~w_grant1;

  // The slot can take a new result if empty or being drained this cycle.
  assign w_free = (r_state == EMPTY) |
                  ((r_state == FULL0) & rsp0_ready) |
                  ((r_state == FULL1) & rsp1_ready);

  assign req0_ready = rst_n & w_free & w_grant0;
  assign req1_ready = rst_n & w_free & w_grant1;
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;

  // ---------------------------------------------------------------------
  // Shared ALU operating on the granted port's operands.
  // ---------------------------------------------------------------------
  assign w_fn = w_grant1 ? req1_alufn : req0_alufn;
  assign w_a  = w_grant1 ? req1_a     : req0_a;
  assign w_b  = w_grant1 ? req1_b     : req0_b;

  assign w_bx    = w_b ^ {32{w_fn[0]}};
  assign w_add   = w_a + w_bx + {31'b0, w_fn[0]};
  assign w_add_v = (w_a[31] == w_bx[31]) & (w_add[31] != w_a[31]);
  assign w_diff  = w_a - w_b;
  assign w_sub_z = (w_diff == 32'd0);
  assign w_sub_n = w_diff[31];
  assign w_sub_v = (w_a[31] != w_b[31]) & (w_diff[31] != w_a[31]);
  assign w_lt    = w_sub_n ^ w_sub_v;

  // Each boolean result bit looks up a 4-entry truth table in alufn[3:0].
  for (genvar gi = 0; gi < 32; gi++) begin : g_bool
    assign w_bool[gi] = w_fn[{w_b[gi], w_a[gi]}];
  end

  // Compare result bit selected by alufn[2:1].
  always_comb begin
    case (w_fn[2:1])
      2'b01:   w_lsb = w_sub_z;
      2'b10:   w_lsb = w_lt;
      2'b11:   w_lsb = w_sub_z | w_lt;
      default: w_lsb = 1'b0;
    endcase
  end

  // Unit select on alufn[5:4]; code 10 is reserved and returns zero.
  always_comb begin
    w_alu_s = 32'd0;
    w_alu_z = 1'b1;
    w_alu_v = 1'b0;
    w_alu_n = 1'b0;
    case (w_fn[5:4])
      2'b00: begin
        w_alu_s = w_add;
        w_alu_z = (w_add == 32'd0);
        w_alu_v = w_add_v;
        w_alu_n = w_add[31];
      end
      2'b01: begin
        w_alu_s = w_bool;
        w_alu_z = (w_bool == 32'd0);
        w_alu_v = 1'b0;
        w_alu_n = w_bool[31];
      end
      2'b11: begin
        w_alu_s = {31'b0, w_lsb};
        w_alu_z = w_sub_z;
        w_alu_v = w_sub_v;
        w_alu_n = w_sub_n;
      end
      default: begin
        w_alu_s = 32'd0;
        w_alu_z = 1'b1;
        w_alu_v = 1'b0;
        w_alu_n = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Result slot: capture on accept, release on drain, otherwise hold.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_s     <= 32'd0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
      r_n     <= 1'b0;
    end else if (w_acc0 || w_acc1) begin
      r_state <= w_acc1 ? FULL1 : FULL0;
      r_s     <= w_alu_s;
      r_z     <= w_alu_z;
      r_v     <= w_alu_v;
      r_n     <= w_alu_n;
    end else if (w_free) begin
      r_state <= EMPTY;
    end
  end

  assign rsp0_valid = (r_state == FULL0);
  assign rsp1_valid = (r_state == FULL1);
  assign rsp0_s     = r_s;
  assign rsp0_z     = r_z;
  assign rsp0_v     = r_v;
  assign rsp0_n     = r_n;
  assign rsp1_s     = r_s;
  assign rsp1_z     = r_z;
  assign rsp1_v     = r_v;
  assign rsp1_n     = r_n;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a reference model (arithmetic ALU, slot as
// full/owner/result, grant rules) is checked every cycle, plus directed
// transactions with hand-computed results. Builds with or without
// ALU_ARB_RR_EN.
module tb_alu_arbiter;
  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_alufn = '0, req1_alufn = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_s, rsp1_s;
  logic        rsp0_z, rsp0_v, rsp0_n, rsp1_z, rsp1_v, rsp1_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alufn(req0_alufn),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alufn(req1_alufn),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s),
    .rsp0_z(rsp0_z), .rsp0_v(rsp0_v), .rsp0_n(rsp0_n),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s),
    .rsp1_z(rsp1_z), .rsp1_v(rsp1_v), .rsp1_n(rsp1_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU in plain signed arithmetic; returns {s,z,v,n}.
  function automatic logic [34:0] ref_alu(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, full;
    longint max_i = 64'sd2147483647;
    longint min_i = -64'sd2147483648;
    logic [31:0] s;
    logic z, v, n, lsb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = '0; z = 1'b1; v = 1'b0; n = 1'b0;
    case (fn[5:4])
      2'b00: begin
        full = fn[0] ? (sa - sb) : (sa + sb);
        s = full[31:0];
        v = (full > max_i) || (full < min_i);
        z = (s == 32'd0);
        n = s[31];
      end
      2'b01: begin
        for (int i = 0; i < 32; i++) s[i] = fn[{b[i], a[i]}];
        z = (s == 32'd0);
        n = s[31];
      end
      2'b11: begin
        full = sa - sb;
        v = (full > max_i) || (full < min_i);
        z = (a == b);
        n = full[31];
        case (fn[2:1])
          2'b01:   lsb = (a == b);
          2'b10:   lsb = (sa < sb);
          2'b11:   lsb = (sa <= sb);
          default: lsb = 1'b0;
        endcase
        s = {31'b0, lsb};
      end
      default: begin
        s = '0; z = 1'b1; v = 1'b0; n = 1'b0;
      end
    endcase
    return {s, z, v, n};
  endfunction

  // Model state: slot occupancy, owner, held result, arbitration history.
  logic        m_full = 1'b0;
  int          m_owner = 0;
  logic [34:0] m_res = '0;
  int          m_cnt = 0;
  int          m_last = 1;
  logic        m_free, m_pick1, m_g0, m_g1, m_e0, m_e1;
  logic        rec_en = 1'b0;
  int          acc_q[$];

  // Compare process: every falling edge, check DUT against the model,
  // then advance the model to what the next rising edge must produce.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_full = 1'b0; m_owner = 0; m_res = '0; m_cnt = 0; m_last = 1;
      end
      m_free = !m_full || (m_owner == 0 ? rsp0_ready : rsp1_ready);
`ifdef ALU_ARB_RR_EN
      m_pick1 = (m_last == 0);
`else
      m_pick1 = (m_cnt >= STARVE);
`endif
      m_g1 = req1_valid && (!req0_valid || m_pick1);
      m_g0 = req0_valid && !m_g1;
      m_e0 = rst_n && m_free && m_g0;
      m_e1 = rst_n && m_free && m_g1;
      chk("model req0_ready", req0_ready, m_e0);
      chk("model req1_ready", req1_ready, m_e1);
      chk("model rsp0_valid", rsp0_valid, m_full && m_owner == 0);
      chk("model rsp1_valid", rsp1_valid, m_full && m_owner == 1);
      if (m_full && m_owner == 0) chk("model rsp0 data", {rsp0_s, rsp0_z, rsp0_v, rsp0_n}, m_res);
      if (m_full && m_owner == 1) chk("model rsp1 data", {rsp1_s, rsp1_z, rsp1_v, rsp1_n}, m_res);
      if (rec_en) begin
        if ((req0_valid && req0_ready) && !(req1_valid && req1_ready)) acc_q.push_back(0);
        else if ((req1_valid && req1_ready) && !(req0_valid && req0_ready)) acc_q.push_back(1);
        else acc_q.push_back(2);
      end
      if (rst_n && rsp0_valid && rsp0_ready)
        $display("rsp0 s=%h z=%b v=%b n=%b", rsp0_s, rsp0_z, rsp0_v, rsp0_n);
      if (rst_n && rsp1_valid && rsp1_ready)
        $display("rsp1 s=%h z=%b v=%b n=%b", rsp1_s, rsp1_z, rsp1_v, rsp1_n);
      if (rst_n) begin
        if (m_e0 || m_e1) begin
          m_res = m_e1 ? ref_alu(req1_alufn, req1_a, req1_b) : ref_alu(req0_alufn, req0_a, req0_b);
          m_full = 1'b1;
          m_owner = m_e1 ? 1 : 0;
`ifdef ALU_ARB_RR_EN
          m_last = m_owner;
`else
          if (m_e1) m_cnt = 0;
          else if (req1_valid) m_cnt++;
`endif
        end else if (m_free) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // Single transaction on one port; checks the response literally.
  task automatic issue(input int port, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [34:0] exp, input string name);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (port == 0) begin
      req0_alufn = fn; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_alufn = fn; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (port == 0) ? req0_ready : req1_ready;
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL %s: accept timeout got ready=0 expected ready=1", name);
    end
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    @(negedge clk);
    if (port == 0) begin
      chk({name, " valid"}, rsp0_valid, 1'b1);
      chk({name, " result"}, {rsp0_s, rsp0_z, rsp0_v, rsp0_n}, exp);
    end else begin
      chk({name, " valid"}, rsp1_valid, 1'b1);
      chk({name, " result"}, {rsp1_s, rsp1_z, rsp1_v, rsp1_n}, exp);
    end
  endtask

  initial begin
    int exp_port;
    // Reset state, with a request presented that must not see ready.
    req0_valid = 1'b1;
    #1;
    chk("reset req0_ready", req0_ready, 1'b0);
    chk("reset rsp0_valid", rsp0_valid, 1'b0);
    chk("reset rsp1_valid", rsp1_valid, 1'b0);
    chk("reset result", rsp0_s, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;

    // Directed ALU transactions, expected {s,z,v,n} computed by hand.
    issue(0, 6'b000000, 32'h7FFFFFFF, 32'd1, {32'h80000000, 1'b0, 1'b1, 1'b1}, "add ovf");
    issue(1, 6'b110101, 32'hFFFFFFFF, 32'd0, {32'h00000001, 1'b0, 1'b0, 1'b1}, "cmp lt");
    issue(1, 6'b110111, 32'd5, 32'd5, {32'h00000001, 1'b1, 1'b0, 1'b0}, "cmp le");
    issue(0, 6'b010110, 32'hF0F0F0F0, 32'hFF00FF00, {32'h0FF00FF0, 1'b0, 1'b0, 1'b0}, "xor");
    issue(0, 6'b011000, 32'hF0F0F0F0, 32'hFF00FF00, {32'hF000F000, 1'b0, 1'b0, 1'b1}, "and");
    issue(1, 6'b000001, 32'd5, 32'd7, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b1}, "sub neg");
    issue(0, 6'b000001, 32'h80000000, 32'd1, {32'h7FFFFFFF, 1'b0, 1'b1, 1'b0}, "sub ovf");
    issue(0, 6'b100000, 32'd123, 32'd456, {32'h00000000, 1'b1, 1'b0, 1'b0}, "reserved");
    issue(1, 6'b110000, 32'd3, 32'd3, {32'h00000000, 1'b1, 1'b0, 1'b0}, "cmp none");

    // Stalled response blocks both ports; drain cycle accepts pending req1.
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    issue(0, 6'b000000, 32'd100, 32'd23, {32'd123, 1'b0, 1'b0, 1'b0}, "stall fill");
    @(posedge clk); #1;
    req1_alufn = 6'b010110; req1_a = 32'd1; req1_b = 32'd3; req1_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("stall rsp0 held", {rsp0_valid, rsp0_s, rsp0_z, rsp0_v, rsp0_n},
          {1'b1, 32'd123, 1'b0, 1'b0, 1'b0});
      chk("stall req0_ready", req0_ready, 1'b0);
      chk("stall req1_ready", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("drain req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("drain rsp1 result", {rsp1_valid, rsp1_s, rsp1_z, rsp1_v, rsp1_n},
        {1'b1, 32'd2, 1'b0, 1'b0, 1'b0});
    chk("drain rsp0_valid", rsp0_valid, 1'b0);

    // Reset while FULL1 discards the held result.
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    issue(1, 6'b110011, 32'd7, 32'd7, {32'd1, 1'b1, 1'b0, 1'b0}, "full1 eq");
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_alufn = 6'b000000; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
    #1;
    chk("rst rsp1_valid drop", rsp1_valid, 1'b0);
    chk("rst clears result", rsp1_s, 32'd0);
    @(negedge clk);
    chk("rst req0_ready", req0_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post-rst rsp1_valid", rsp1_valid, 1'b0);
      chk("post-rst rsp0_valid", rsp0_valid, 1'b0);
    end
    issue(0, 6'b000000, 32'd2, 32'd3, {32'd5, 1'b0, 1'b0, 1'b0}, "post-rst add");

    // Both ports valid every cycle, responses always ready.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_alufn = 6'b000000; req0_a = 32'd1;  req0_b = 32'd2;
    req1_alufn = 6'b000001; req1_a = 32'd10; req1_b = 32'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rec_en = 1'b1;
    repeat (18) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rec_en = 1'b0;
    chk("grant count", acc_q.size(), 18);
    for (int i = 0; i < 18 && i < acc_q.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      exp_port = i % 2;
`else
      exp_port = (i % 9 == 8) ? 1 : 0;
`endif
      chk($sformatf("grant seq %0d", i), acc_q[i], exp_port);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 8: the maximum number of consecutive port-0 grants while port 1 waits, applied in fixed-priority mode only.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports reqK_valid (input, 1 bit) and reqK_ready (output, 1 bit), K=0,1: the request handshake for each port.
REQ-005 The module SHALL have ports reqK_alufn (input, 6 bits), reqK_a (input, 32 bits) and reqK_b (input, 32 bits), K=0,1: the operation code and operands.
REQ-006 The module SHALL have ports rspK_valid (output, 1 bit) and rspK_ready (input, 1 bit), K=0,1: the response handshake for each port.
REQ-007 The module SHALL have ports rspK_s (output, 32 bits) and rspK_z, rspK_v, rspK_n (outputs, 1 bit each), K=0,1: the result and flags.

Function
REQ-008 The block SHALL share one combinational ALU between two requesters and hold one shared result register with an owner tag.
REQ-009 Unit selection SHALL use alufn[5:4]: 00 add/sub, 01 boolean, 11 compare, 10 reserved.
REQ-010 Add/sub SHALL compute s = a + (b ^ {32{alufn[0]}}) + alufn[0], with z = (s==0), v = signed overflow of that addition and n = s[31].
REQ-011 Boolean SHALL compute each bit s[i] = alufn[{b[i],a[i]}] (a 4-bit truth table), with z = (s==0), v = 0 and n = s[31].
REQ-012 Compare SHALL compute a-b internally, then set s = {31'b0,lsb}, where lsb is z for alufn[2:1]=01, n^v for 10, z|(n^v) for 11 and 0 for 00; flags SHALL come from the subtraction.
REQ-013 Reserved unit code 10 SHALL return s = 0, z = 1, v = 0, n = 0.
REQ-014 The result register SHALL use states EMPTY and FULL0/FULL1, where FULLK means a result is held for port K.
REQ-015 The slot SHALL be free when the state is EMPTY, or when it is FULLK and rspK_valid & rspK_ready is true in the same cycle (drain and refill in one cycle).
REQ-016 Grant SHALL be combinational among valid requesters; reqK_ready = grantK & slot free; only the granted port sees ready.
REQ-017 An accept (reqK_valid & reqK_ready) at edge N SHALL produce rspK_valid = 1 after edge N, holding the ALU outputs for the captured operands: one-cycle latency.
REQ-018 rspK_valid SHALL be 1 only in state FULLK; rspK_s/z/v/n SHALL show the register contents and be stable while rspK_valid & !rspK_ready.
REQ-019 A stalled response on one port SHALL block both ports (single slot); no request SHALL be accepted while the slot is not free.
REQ-020 Requesters SHALL hold alufn, a and b stable while valid & !ready; the block does not check this.
REQ-021 With no valid requester, the state SHALL go to EMPTY on drain, otherwise remain unchanged.

Reset
REQ-022 rst_n low SHALL immediately force state EMPTY, rsp0_valid = rsp1_valid = 0, result register = 0, the round-robin pointer to favour port 0 and the starvation counter to 0.
REQ-023 Reset mid-operation SHALL discard any held result; no response SHALL appear after reset release until a new accept.
REQ-024 While rst_n is low, reqK_ready SHALL be 0.

Configuration
REQ-025 With macro ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie the port not most recently granted wins, the pointer updates on each accept, and STARVE_LIMIT is ignored.
REQ-026 Without ALU_ARB_RR_EN, port 0 SHALL have fixed priority.
REQ-027 In fixed-priority mode, the starvation counter SHALL increment on each port-0 accept while req1_valid = 1 and clear on any port-1 accept.
REQ-028 In fixed-priority mode, when the counter equals STARVE_LIMIT, port 1 SHALL be granted on a tie.

Verification
REQ-029 Reset, then a port-0 add with a=32'h7FFFFFFF, b=1, alufn=6'b000000 -> rsp0 one cycle later with s=32'h80000000, v=1, n=1, z=0.
REQ-030 Compare LT (alufn=6'b110101), a=32'hFFFFFFFF, b=0, port 1 -> s=1; with a=5, b=5 and LE (6'b110111) -> s=1.
REQ-031 Boolean XOR (alufn=6'b010110), a=32'hF0F0F0F0, b=32'hFF00FF00 -> s=32'h0FF00FF0, z=0.
REQ-032 Both ports valid every cycle, responses always ready: with ALU_ARB_RR_EN grants alternate 0,1,0,1; without it port 1 is granted every ninth accept (STARVE_LIMIT=8).
REQ-033 rsp0_ready held low 3 cycles -> rsp0 outputs stable, req0_ready and req1_ready both 0; on the drain cycle a pending req1 is accepted and rsp1_valid rises the next cycle.
REQ-034 rst_n asserted while FULL1 -> rsp1_valid drops immediately; nothing is returned after release until a new accept.
